// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl: splits one (base, words, dir) job into AXI bursts on dma_axi's native port.
// Latency: cfg_start to first valid is 3 cycles with dma_ready high, then up to one beat per cycle.
// Backpressure: write beats follow s_valid/ready; read beats pause while the m output register is full.
// Build option DMA_BOUNDARY_4K_EN: when defined, no burst crosses a 4KB address boundary.
module dma_burst_ctrl #(
   parameter int DMA_DATA_W = 32,
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_LEN_W  = 8,
   parameter int MAX_BURST  = 16,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_start,
   input  logic                    cfg_dir,
   input  logic [AXI_ADDR_W-1:0]   cfg_addr,
   input  logic [CNT_W-1:0]        cfg_words,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   input  logic                    s_valid,
   input  logic [DMA_DATA_W-1:0]   s_data,
   output logic                    s_ready,
   output logic                    m_valid,
   output logic [DMA_DATA_W-1:0]   m_data,
   input  logic                    m_ready,
   output logic                    valid,
   output logic [AXI_ADDR_W-1:0]   address,
   output logic [DMA_DATA_W-1:0]   wdata,
   output logic [DMA_DATA_W/8-1:0] wstrb,
   input  logic [DMA_DATA_W-1:0]   rdata,
   input  logic                    ready,
   output logic [AXI_LEN_W-1:0]    dma_len,
   input  logic                    dma_ready,
   input  logic                    error
);
   localparam int BPW    = DMA_DATA_W / 8;
   localparam int BLEN_W = AXI_LEN_W + 1;
   localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = ~(AXI_ADDR_W'(BPW - 1));

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_WAIT, S_BEAT, S_FIN} state_t;
   state_t state, state_nxt;

   logic [AXI_ADDR_W-1:0] base;
   logic [CNT_W-1:0]      remaining;
   logic                  dir;
   logic [BLEN_W-1:0]     blen;
   logic [BLEN_W-1:0]     beat_cnt;
   logic [BLEN_W-1:0]     blen_calc;
   logic [31:0]           len_sel;
   logic                  start_ok, in_burst, err_now, fire, last_beat, job_over;

   assign start_ok  = (state == S_IDLE) && cfg_start;
   // beat_cnt==0 inside S_BEAT means the read burst is over and we only wait for m to drain
   assign in_burst  = (state == S_BEAT) && (beat_cnt != '0);
   assign err_now   = err | error;
   assign fire      = valid & ready;
   assign last_beat = fire && (beat_cnt == BLEN_W'(1));
   assign job_over  = (remaining == CNT_W'(blen)) || err_now;

   assign busy    = (state == S_CALC) || (state == S_WAIT) || (state == S_BEAT);
   assign done    = (state == S_FIN);
   assign address = base;
   assign wdata   = s_data;

`ifdef DMA_BOUNDARY_4K_EN
   logic [12:0] page_bytes;
   logic [12:0] page_words;
   assign page_bytes = 13'd4096 - {1'b0, base[11:0]};
   assign page_words = page_bytes / 13'(BPW);
`endif

   // Burst length: smallest of MAX_BURST, words left and (optionally) words left in the 4KB page.
   always_comb begin
      len_sel = (32'(remaining) < 32'(MAX_BURST)) ? 32'(remaining) : 32'(MAX_BURST);
`ifdef DMA_BOUNDARY_4K_EN
      if (32'(page_words) < len_sel) len_sel = 32'(page_words);
`endif
      blen_calc = BLEN_W'(len_sel);
   end

   // Steer beats: write beats pass the s stream through, read beats need room in the m register.
   always_comb begin
      valid   = 1'b0;
      s_ready = 1'b0;
      wstrb   = '0;
      if (in_burst) begin
         if (dir) begin
            valid   = s_valid;
            s_ready = ready;
            wstrb   = '1;
         end else begin
            valid = ~m_valid | m_ready;
         end
      end
   end

   // Next-state logic; an error stops new bursts but never cuts one short or strands read data.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (cfg_start) state_nxt = (cfg_words == '0) ? S_FIN : S_CALC;
         S_CALC: begin
            if (!err_now) state_nxt = S_WAIT;
            else if (dir || !m_valid) state_nxt = S_FIN;
         end
         S_WAIT: begin
            if (err_now) begin
               if (dir || !m_valid) state_nxt = S_FIN;
            end else if (dma_ready) begin
               state_nxt = S_BEAT;
            end
         end
         S_BEAT: begin
            if (beat_cnt == '0) begin
               if (!m_valid) state_nxt = S_FIN;
            end else if (last_beat) begin
               if (!job_over) state_nxt = S_CALC;
               else if (dir) state_nxt = S_FIN;
            end
         end
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Job bookkeeping, burst sizing, sticky error and the read output register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         base      <= '0;
         remaining <= '0;
         dir       <= 1'b0;
         blen      <= '0;
         beat_cnt  <= '0;
         dma_len   <= '0;
         err       <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
      end else begin
         if (start_ok) begin
            base      <= cfg_addr & ADDR_MASK;
            remaining <= cfg_words;
            dir       <= cfg_dir;
            err       <= 1'b0;
         end else if (busy && error) begin
            err <= 1'b1;
         end
         if (state == S_CALC) begin
            blen     <= blen_calc;
            beat_cnt <= blen_calc;
            dma_len  <= AXI_LEN_W'(blen_calc - BLEN_W'(1));
         end
         if (fire) beat_cnt <= beat_cnt - BLEN_W'(1);
         if (last_beat) begin
            base      <= base + AXI_ADDR_W'(blen) * AXI_ADDR_W'(BPW);
            remaining <= remaining - CNT_W'(blen);
         end
         if (fire && !dir) begin
            m_valid <= 1'b1;
            m_data  <= rdata;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end
endmodule
